// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MDU_MADD_EN to build the madd/maddu/msub/msubu accumulate ops.
module mult_div_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       md_op,
    input  logic             req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int unsigned DW      = 2 * WIDTH;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_d, lo_d;

    logic             op_signed;
    logic [DW-1:0]    ext_a, ext_b, prod, res;
    logic             res_wr;
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b, div_b, uq, ur, quo, rem;

    // Datapath: evaluated from the latched operands and committed HI/LO.
    always_comb begin
        case (op_q)
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB,
`endif
            OP_MULT, OP_DIV: op_signed = 1'b1;
            default:         op_signed = 1'b0;
        endcase

        ext_a = {{WIDTH{a_q[WIDTH-1] & op_signed}}, a_q};
        ext_b = {{WIDTH{b_q[WIDTH-1] & op_signed}}, b_q};
        prod  = ext_a * ext_b;

        // Signed divide runs on magnitudes; most-negative / -1 falls out as
        // quotient = most-negative, remainder = 0 without a special case.
        neg_a = op_signed & a_q[WIDTH-1];
        neg_b = op_signed & b_q[WIDTH-1];
        mag_a = neg_a ? (WIDTH'(0) - a_q) : a_q;
        mag_b = neg_b ? (WIDTH'(0) - b_q) : b_q;
        div_b = (mag_b == WIDTH'(0)) ? WIDTH'(1) : mag_b;
        uq    = mag_a / div_b;
        ur    = mag_a % div_b;
        quo   = (neg_a ^ neg_b) ? (WIDTH'(0) - uq) : uq;
        rem   = neg_a ? (WIDTH'(0) - ur) : ur;

        res    = prod;
        res_wr = 1'b1;
        case (op_q)
            OP_DIV, OP_DIVU: begin
                res    = {rem, quo};
                res_wr = (b_q != WIDTH'(0));
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: res = {hi, lo} + prod;
            OP_MSUB, OP_MSUBU: res = {hi, lo} - prod;
`endif
            default: ;
        endcase
    end

    // Next-state: accept in IDLE when req is low, commit when the count hits 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi;
        lo_d    = lo;
        case (state_q)
            IDLE: begin
                if (!req) begin
                    case (md_op)
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
`endif
                        OP_MULT, OP_MULTU: begin
                            state_d = RUN;
                            cnt_d   = CNT_W'(MUL_CYCLES);
                            op_d    = md_op;
                            a_d     = a;
                            b_d     = b;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = RUN;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            op_d    = md_op;
                            a_d     = a;
                            b_d     = b;
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = CNT_W'(0);
                    if (res_wr) begin
                        hi_d = res[DW-1:WIDTH];
                        lo_d = res[WIDTH-1:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi      <= hi_d;
            lo      <= lo_d;
            busy    <= (state_d == RUN);
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a behavioural HI/LO model pushes the
// expected {hi,lo} per op; it is popped once busy drops.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b;
    logic [3:0]  md_op;
    logic        req;
    logic [31:0] hi, lo;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] sb_q[$];

    mult_div_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .md_op(md_op), .req(req),
        .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Architectural model; returns the expected busy cycle count.
    task automatic model_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                            output int cyc);
        longint sa, sb, ua, ub;
        logic [63:0] acc;
        sa  = longint'($signed(av));
        sb  = longint'($signed(bv));
        ua  = longint'(av);
        ub  = longint'(bv);
        acc = {m_hi, m_lo};
        cyc = 0;
        case (op)
            4'd1: begin {m_hi, m_lo} = 64'(sa * sb); cyc = 5; end
            4'd2: begin {m_hi, m_lo} = 64'(ua * ub); cyc = 5; end
            4'd3: begin
                cyc = 10;
                if (bv != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            end
            4'd4: begin
                cyc = 10;
                if (bv != 0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
            end
            4'd5: m_hi = av;
            4'd6: m_lo = av;
`ifdef MDU_MADD_EN
            4'd7:  begin {m_hi, m_lo} = acc + 64'(sa * sb); cyc = 5; end
            4'd8:  begin {m_hi, m_lo} = acc + 64'(ua * ub); cyc = 5; end
            4'd9:  begin {m_hi, m_lo} = acc - 64'(sa * sb); cyc = 5; end
            4'd10: begin {m_hi, m_lo} = acc - 64'(ua * ub); cyc = 5; end
`endif
            default: ;
        endcase
    endtask

    // Entered at a negedge; holds the request for one cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic r);
        md_op = op; a = av; b = bv; req = r;
        @(negedge clk);
        md_op = 4'd0; req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int n = 0;
        logic [63:0] e;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy"}, 64'(n), 64'(exp_cyc));
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(1), 64'(0));
        end else begin
            e = sb_q.pop_front();
            check({tag, "_hilo"}, {hi, lo}, e);
        end
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic r);
        int cyc = 0;
        if (!r) model_op(op, av, bv, cyc);
        sb_q.push_back({m_hi, m_lo});
        issue(op, av, bv, r);
        wait_done(tag, cyc);
    endtask

    initial begin
        int cyc;
        reset = 1'b1; a = '0; b = '0; md_op = '0; req = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;

        run("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run("mult_nn", 4'd1, 32'hFFFF_FF00, 32'h8000_0000, 1'b0);
        run("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        run("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run("divu", 4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("divu_const", {hi, lo}, 64'h0000_0001_7FFF_FFFC);

        // mthi during busy is dropped; operand change after acceptance is harmless
        model_op(4'd1, 32'd1000, 32'd1000, cyc);
        sb_q.push_back({m_hi, m_lo});
        issue(4'd1, 32'd1000, 32'd1000, 1'b0);
        check("busy_t1", 64'(busy), 64'd1);
        issue(4'd5, 32'h1234_5678, 32'd0, 1'b0);
        wait_done("mthi_busy", cyc - 1);
        run("mthi_req", 4'd5, 32'h1234_5678, 32'd0, 1'b1);
        run("mthi", 4'd5, 32'h1234_5678, 32'd0, 1'b0);
        check("mthi_const", 64'(hi), 64'h1234_5678);

        run("mthi5", 4'd5, 32'd5, 32'd0, 1'b0);
        run("mtlo7", 4'd6, 32'd7, 32'd0, 1'b0);
        run("div0", 4'd3, 32'd100, 32'd0, 1'b0);
        check("div0_const", {hi, lo}, 64'h0000_0005_0000_0007);
        run("divu0", 4'd4, 32'd100, 32'd0, 1'b0);
        run("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        run("div_neg", 4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);

        // req during RUN must not abort
        model_op(4'd2, 32'hDEAD_BEEF, 32'h1234_5678, cyc);
        sb_q.push_back({m_hi, m_lo});
        issue(4'd2, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        req = 1'b1;
        wait_done("req_run", cyc);
        req = 1'b0;

        run("op11", 4'd11, 32'hAAAA_AAAA, 32'd3, 1'b0);
        run("op15", 4'd15, 32'h5555_5555, 32'd3, 1'b0);

        // reset in the 3rd busy cycle discards the mult
        issue(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (2) @(negedge clk);
        check("busy_c3", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_hilo", {hi, lo}, 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        run("mult67", 4'd1, 32'd6, 32'd7, 1'b0);
        check("mult67_lo", 64'(lo), 64'd42);

        run("mtlo_f", 4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run("mthi_0", 4'd5, 32'd0, 32'd0, 1'b0);
        run("maddu", 4'd8, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
        check("maddu_const", {hi, lo}, 64'h0000_0001_0000_0000);
        run("msub", 4'd9, 32'hFFFF_FFFF, 32'd3, 1'b0);
        run("madd", 4'd7, 32'h8000_0000, 32'd2, 1'b0);
        run("msubu", 4'd10, 32'hFFFF_FFFF, 32'd2, 1'b0);
`else
        check("maddu_const", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
        run("msub", 4'd9, 32'hFFFF_FFFF, 32'd3, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width (min 8).
REQ-002 SHALL have parameter MUL_CYCLES, default 5, busy cycles for multiply-class ops (min 1).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, busy cycles for divide-class ops (min 1).
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port a  input  WIDTH  operand A (rs), also the mthi/mtlo data.
REQ-007 SHALL have port b  input  WIDTH  operand B (rt).
REQ-008 SHALL have port md_op  input  4  operation request: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11-15 none.
REQ-009 SHALL have port req  input  1  exception/interrupt request; blocks acceptance in the same cycle.
REQ-010 SHALL have port hi  output  WIDTH  architectural HI register.
REQ-011 SHALL have port lo  output  WIDTH  architectural LO register.
REQ-012 SHALL have port busy  output  1  high while a multi-cycle op is in flight.

Function
REQ-013 SHALL accept md_op in cycle T only if busy=0 and req=0; otherwise md_op SHALL be ignored.
REQ-014 SHALL, for accepted mthi/mtlo, write a into hi/lo at the edge ending T, no busy assertion.
REQ-015 SHALL, for an accepted multi-cycle op, latch operands and op at the edge ending T, assert busy for cycles T+1..T+N (N = MUL_CYCLES or DIV_CYCLES), and update hi/lo at the edge ending T+N; busy=0 and new values visible in T+N+1.
REQ-016 SHALL use a two-state FSM (IDLE, RUN) with a down-counter of width clog2(max(MUL_CYCLES,DIV_CYCLES))+1; RUN->IDLE when the counter reaches 1.
REQ-017 SHALL hold hi/lo unchanged during RUN; outputs reflect only committed results.
REQ-018 SHALL compute mult/multu as a 2*WIDTH signed/unsigned product; {hi,lo} = product.
REQ-019 SHALL compute div/divu with lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-020 SHALL leave hi/lo unchanged on divide by zero (b=0), still consuming DIV_CYCLES busy cycles.
REQ-021 SHALL, for signed div of most-negative by -1, set lo = most-negative, hi = 0.
REQ-022 SHALL compute madd/maddu as {hi,lo} += product, msub/msubu as {hi,lo} -= product, modulo 2^(2*WIDTH), using {hi,lo} committed at acceptance.
REQ-023 SHALL not abort an in-flight op when req rises during RUN; it completes normally.
REQ-024 SHALL treat md_op codes 11-15 as none (no state change).

Reset
REQ-025 SHALL, on reset=1 at any time (including mid-RUN), immediately force hi=0, lo=0, busy=0, FSM=IDLE, counter=0, discarding any in-flight op.
REQ-026 SHALL accept a new op in the first cycle after reset deasserts.

Configuration
REQ-027 SHALL compile madd/maddu/msub/msubu support only when macro MDU_MADD_EN is defined.
REQ-028 SHALL, without MDU_MADD_EN, treat codes 7-10 as none: no busy, no hi/lo change.

Verification
REQ-029 SHALL verify: WIDTH=32, MUL_CYCLES=5, mult a=0xFFFFFFFE b=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFA.
REQ-030 SHALL verify: div a=0xFFFFFFF9 (-7) b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu same operands -> lo=0x7FFFFFFC, hi=1.
REQ-031 SHALL verify: mthi a=0x12345678 while busy=1 -> ignored; same with req=1 and busy=0 -> ignored; with req=0,busy=0 -> hi=0x12345678 next cycle, busy stays 0.
REQ-032 SHALL verify: hi=5 lo=7 preset, div b=0 -> busy 10 cycles, hi=5 lo=7 retained; div 0x80000000 by 0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-033 SHALL verify: mult started, reset pulsed in 3rd busy cycle -> hi=lo=0, busy=0 immediately; mult 6*7 next -> lo=42.
REQ-034 SHALL verify with MDU_MADD_EN: hi=0 lo=0xFFFFFFFF, maddu a=1 b=1 -> hi=1 lo=0; without macro same stimulus -> busy stays 0, hi/lo unchanged.
